// File: rtl/serial_alu_pkg.sv
// Shared encodings for the bit-serial ALU sequencer: opcodes, FSM states, flag bit positions,
// and the slice-control decode that maps each opcode onto the 1-bit ALU slice inputs.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD   = 2'd0;
  localparam logic [1:0] OP_SUB   = 2'd1;
  localparam logic [1:0] OP_PASSB = 2'd2;
  localparam logic [1:0] OP_NEGB  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // PASSB and NEGB gate operand A off so the slice computes 0 + B (+cin).
  function automatic logic op_aen(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic op_binv(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_NEGB);
  endfunction

  // Subtraction and negation are done as A + ~B + 1, so they start with carry set.
  function automatic logic op_carry0(input logic [1:0] op);
    return op_binv(op) && (op != OP_PASSB);
  endfunction

endpackage

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer feeding an external 1-bit ALU slice, LSB first, with a valid/ready result port.
// Optional macro SERIAL_ALU_FLAGS_EN builds the N/Z/C/V flag logic; otherwise flags reads 4'b0000.
module serial_alu_seq
  import serial_alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             slc_a,
  output logic             slc_b,
  output logic             slc_aen,
  output logic             slc_binv,
  output logic             slc_cin,
  output logic             slc_reset,
  input  logic             slc_sum,
  input  logic             slc_cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               res_valid_q, res_valid_d;
`ifdef SERIAL_ALU_FLAGS_EN
  logic               zacc_q, zacc_d;
  logic [3:0]         flags_q, flags_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    carry_d     = carry_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    op_d        = op_q;
    result_d    = result_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
`ifdef SERIAL_ALU_FLAGS_EN
    zacc_d      = zacc_q;
    flags_d     = flags_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = opa;
          b_sh_d  = opb;
          op_d    = op;
          count_d = '0;
          carry_d = op_carry0(op);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef SERIAL_ALU_FLAGS_EN
          zacc_d  = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        if (count_q > LAST) begin
          // Unreachable for power-of-two widths; recovers a corrupted counter otherwise.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          result_d = {slc_sum, result_q[WIDTH-1:1]};
          carry_d  = slc_cout;
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          count_d  = count_q + 1'b1;
`ifdef SERIAL_ALU_FLAGS_EN
          zacc_d   = zacc_q | slc_sum;
`endif
          if (count_q == LAST) begin
            count_d     = '0;
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
`ifdef SERIAL_ALU_FLAGS_EN
            // carry_q is the carry into the MSB, slc_cout the carry out of it.
            flags_d[FLG_N] = slc_sum;
            flags_d[FLG_Z] = ~(zacc_q | slc_sum);
            flags_d[FLG_C] = slc_cout;
            flags_d[FLG_V] = carry_q ^ slc_cout;
`endif
          end
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      zacc_q      <= 1'b0;
      flags_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      op_q        <= op_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
`ifdef SERIAL_ALU_FLAGS_EN
      zacc_q      <= zacc_d;
      flags_q     <= flags_d;
`endif
    end
  end

  logic shifting;
  assign shifting = (state_q == ST_SHIFT);

  // Slice inputs are quiet and the sum forced outside SHIFT so the slice never sees stale operands.
  assign slc_a     = shifting & a_sh_q[0];
  assign slc_b     = shifting & b_sh_q[0];
  assign slc_aen   = shifting & op_aen(op_q);
  assign slc_binv  = shifting & op_binv(op_q);
  assign slc_cin   = shifting & carry_q;
  assign slc_reset = ~shifting;

  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
`ifdef SERIAL_ALU_FLAGS_EN
  assign flags     = flags_q;
`else
  assign flags     = 4'b0000;
`endif

endmodule
